freqmeas_module: RTL

FREQMEAS_MODULE -- requirements
Module: freqmeas_module

---
 rtl/freqmeas_pkg.sv | 25 ++
 rtl/sync_edge_module.sv | 36 +++
 rtl/freqmeas_module.sv | 135 +++++++++++++
 3 files changed

// File: rtl/freqmeas_pkg.sv
// ============================================================================
// freqmeas_pkg : shared counter width, FSM encodings and saturating helper
// Rev 1.0
// ============================================================================
`default_nettype none

package freqmeas_pkg;

  localparam int               CNT_W   = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GATE = 1'b1;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_WAIT = 2'd1;
  localparam logic [1:0] P_RUN  = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_module.sv
// ============================================================================
// sync_edge_module : multi-flop synchronizer with registered rising-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge_module #(
  parameter int sync_stages = 2
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [sync_stages-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pulse;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[sync_stages-2:0], din};
      r_prev  <= r_sync[sync_stages-1];
      r_pulse <= r_sync[sync_stages-1] & ~r_prev;
    end
  end

  assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/freqmeas_module.sv
// ============================================================================
// freqmeas_module : gated edge counter (frequency) and edge-to-edge period timer
// Rev 1.0
// ============================================================================
`default_nettype none

module freqmeas_module
  import freqmeas_pkg::*;
#(
  parameter int unsigned gate_cycles = 50000000,
  parameter int          sync_stages = 2
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             sigin,
  input  logic             en,
  output logic [CNT_W-1:0] freq,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             ovf,
  output logic             period_to
);

  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(gate_cycles - 1);

  logic             w_de;
  logic             w_term;
  logic [CNT_W-1:0] w_ecnt_next;

  logic [0:0]       r_gstate;
  logic [CNT_W-1:0] r_gcnt;
  logic [CNT_W-1:0] r_ecnt;
  logic [CNT_W-1:0] r_freq;
  logic             r_ovf;
  logic             r_valid;

  logic [1:0]       r_pstate;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_period;
  logic             r_pto;

  sync_edge_module #(
    .sync_stages(sync_stages)
  ) u_sync_edge (
    .clkin(clkin),
    .rst_n(rst_n),
    .din  (sigin),
    .pulse(w_de)
  );

  assign w_term      = (r_gcnt == c_TERM);
  assign w_ecnt_next = sat_inc(r_ecnt, w_de);

  // Terminal cycle closes the window and restarts counting with no dead cycle
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_gstate <= S_IDLE;
      r_gcnt   <= '0;
      r_ecnt   <= '0;
      r_freq   <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_gstate)
        S_IDLE: begin
          if (en) begin
            r_gstate <= S_GATE;
            r_gcnt   <= '0;
            r_ecnt   <= '0;
          end
        end
        S_GATE: begin
          if (!en) begin
            r_gstate <= S_IDLE;
            r_gcnt   <= '0;
            r_ecnt   <= '0;
          end else if (w_term) begin
            r_freq  <= w_ecnt_next;
            r_ovf   <= (w_ecnt_next == CNT_MAX);
            r_valid <= 1'b1;
            r_gcnt  <= '0;
            r_ecnt  <= '0;
          end else begin
            r_gcnt <= r_gcnt + CNT_W'(1);
            r_ecnt <= w_ecnt_next;
          end
        end
        default: r_gstate <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate <= P_IDLE;
      r_pcnt   <= '0;
      r_period <= '0;
      r_pto    <= 1'b0;
    end else if (!en) begin
      r_pstate <= P_IDLE;
      r_pcnt   <= '0;
    end else begin
      case (r_pstate)
        P_IDLE: r_pstate <= P_WAIT;
        P_WAIT: begin
          if (w_de) begin
            r_pstate <= P_RUN;
            r_pcnt   <= CNT_W'(1);
          end
        end
        P_RUN: begin
          if (w_de) begin
            r_period <= r_pcnt;
            r_pcnt   <= CNT_W'(1);
            r_pto    <= 1'b0;
          end else if (r_pcnt != CNT_MAX) begin
            r_pcnt <= r_pcnt + CNT_W'(1);
            if (r_pcnt == CNT_MAX - CNT_W'(1)) r_pto <= 1'b1;
          end
        end
        default: r_pstate <= P_IDLE;
      endcase
    end
  end

  assign freq      = r_freq;
  assign ovf       = r_ovf;
  assign valid     = r_valid;
  assign period    = r_period;
  assign period_to = r_pto;

endmodule

`default_nettype wire
